// File: rtl/alu_pkg.sv
// Shared opcode map and decode helpers for the pipelined add/sub/abs unit.
package alu_pkg;

  localparam logic [2:0] OP_ADD0  = 3'b000;
  localparam logic [2:0] OP_ADD1  = 3'b100;
  localparam logic [2:0] OP_SUBAB = 3'b001;
  localparam logic [2:0] OP_SUBBA = 3'b101;

  // op[1] set selects one of the absolute-value opcodes (x10 / x11)
  function automatic logic op_is_abs(input logic [2:0] op);
    return op[1];
  endfunction

  // for ABS opcodes, op[2] picks operand A, otherwise operand B
  function automatic logic op_abs_sel_a(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
interface alu_pipe_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r, ovf, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r, ovf, zero
  );
endinterface

// File: rtl/addsub_core.sv
// Combinational two's-complement adder/subtractor: sum = x + (y ^ {sub}) + sub.
module addsub_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             carry
);

  logic [WIDTH-1:0] y_eff;

  // effective add of x and conditionally inverted y; overflow when both
  // addend signs agree and the sum sign differs
  always_comb begin
    y_eff        = y ^ {WIDTH{sub}};
    {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    ovf          = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage signed add/subtract/abs unit with valid/ready on both sides.
// Define ALU_SAT_EN to clamp overflowing results instead of wrapping.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             s1_v, s2_v;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_x, s1_y;
  logic             s1_sub;
  logic [WIDTH-1:0] x_d, y_d, opnd;
  logic             sub_d;
  logic [WIDTH-1:0] core_sum, r_next;
  logic             core_ovf, core_carry;
  logic             unused_ok;

  assign s2_adv       = ~s2_v | bus.out_ready;
  assign s1_adv       = ~s1_v | s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_v;
  assign unused_ok    = core_carry;

  // operand routing: ABS becomes 0 +/- operand, SUBBA swaps operands
  always_comb begin
    opnd  = op_abs_sel_a(bus.op) ? bus.a : bus.b;
    x_d   = bus.a;
    y_d   = bus.b;
    sub_d = 1'b0;
    if (op_is_abs(bus.op)) begin
      x_d   = '0;
      y_d   = opnd;
      sub_d = opnd[WIDTH-1];
    end else begin
      case (bus.op)
        OP_SUBAB: sub_d = 1'b1;
        OP_SUBBA: begin
          x_d   = bus.b;
          y_d   = bus.a;
          sub_d = 1'b1;
        end
        OP_ADD0, OP_ADD1: sub_d = 1'b0;
        default: sub_d = 1'b0;
      endcase
    end
  end

  // stage 1: capture routed operands whenever the stage may advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_sub <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_x   <= x_d;
        s1_y   <= y_d;
        s1_sub <= sub_d;
      end
    end
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x     (s1_x),
    .y     (s1_y),
    .sub   (s1_sub),
    .sum   (core_sum),
    .ovf   (core_ovf),
    .carry (core_carry)
  );

  // final result: on overflow both addends share x's sign, which is the true sign
  always_comb begin
    r_next = core_sum;
`ifdef ALU_SAT_EN
    if (core_ovf) r_next = s1_x[WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
  end

  // stage 2: result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      bus.r    <= '0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        bus.r    <= r_next;
        bus.ovf  <= core_ovf;
        bus.zero <= (r_next == '0);
      end
    end
  end

endmodule
